layer_update_gen: RTL and testbench

- Training-side initiator for the fully-connected `layer` block.
- Converts per-row error deltas and the layer's input activations into gradient-descent weight and bias updates.
- Drives `row_sel`, `weight_update`, `bias_updates` and `train_en` into one layer instance, one row per `train_en` pulse.
- Sits between the backprop/error stage and each layer.

---
 rtl/ann_pkg.sv | 25 ++
 rtl/layer_update_gen_mac.sv | 43 ++++
 rtl/layer_update_gen.sv | 192 +++++++++++++++++++
 tb/tb_layer_update_gen.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ann_pkg.sv
// Shared types and constant helpers for the ann training-side blocks.
// Hosts the update FSM states plus saturation and rounding constants.
package ann_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    PULSE,
    FINISH
  } upd_state_t;

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  // Half an LSB of the post-shift result; zero when nothing is shifted out
  function automatic longint rnd_off(input int sh);
    return (sh == 0) ? 64'sd0 : (longint'(1) <<< (sh - 1));
  endfunction

endpackage

// File: rtl/layer_update_gen_mac.sv
// One (delta, x) weight update: multiply, scale, negate, saturate.
// UPDATE_ROUND_EN selects round-half-up instead of truncation.
module update_mac
  import ann_pkg::*;
#(
  parameter int datawidth = 11,
  parameter int LR_SHIFT  = 4
) (
  input  logic signed [2*datawidth-1:0] delta,
  input  logic signed [datawidth-1:0]   x,
  output logic signed [datawidth-1:0]   u
);

  localparam int PW = 3 * datawidth + 1;

  localparam logic signed [PW-1:0] UMAX =
    PW'(sat_max(datawidth));
  localparam logic signed [PW-1:0] UMIN =
    PW'(sat_min(datawidth));

  logic signed [PW-1:0] p;
  logic signed [PW-1:0] s;
  logic signed [PW-1:0] n;

  always_comb begin
    p = PW'(delta) * PW'(x);
`ifdef UPDATE_ROUND_EN
    p = p + PW'(rnd_off(LR_SHIFT));
`else
    p = p + PW'(0);
`endif
    s = p >>> LR_SHIFT;
    n = -s;
    if (n > UMAX) begin
      u = UMAX[datawidth-1:0];
    end else if (n < UMIN) begin
      u = UMIN[datawidth-1:0];
    end else begin
      u = n[datawidth-1:0];
    end
  end

endmodule

// File: rtl/layer_update_gen.sv
// Sweeps a layer's rows, emitting one weight/bias update per train_en.
// Optional UPDATE_ROUND_EN: round-half-up before the learning-rate shift.
module layer_update_gen
  import ann_pkg::*;
#(
  parameter int rows        = 30,
  parameter int columns     = 64,
  parameter int max_rows    = 30,
  parameter int max_columns = 64,
  parameter int datawidth   = 11,
  parameter int LR_SHIFT    = 4
) (
  input  logic                              clk,
  input  logic                              rst_overall,
  input  logic                              start,
  input  logic [rows*2*datawidth-1:0]       deltas,
  input  logic [columns*datawidth-1:0]      activations,
  output logic [$clog2(max_rows)-1:0]       row_sel,
  output logic [max_columns*datawidth-1:0]  weight_update,
  output logic [max_rows*2*datawidth-1:0]   bias_updates,
  output logic                              train_en,
  output logic                              busy,
  output logic                              done
);

  localparam int DW = datawidth;
  localparam int BW = 2 * datawidth;
  localparam int BX = BW + 2;
  localparam int RW = $clog2(max_rows);
  localparam int CW = (columns > 1) ? $clog2(columns) : 1;

  localparam logic [RW-1:0] LAST_ROW = RW'(rows - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(columns - 1);

  localparam logic signed [BX-1:0] BMAX = BX'(sat_max(BW));
  localparam logic signed [BX-1:0] BMIN = BX'(sat_min(BW));

  upd_state_t state;
  upd_state_t nxt;

  logic [RW-1:0] row;
  logic [CW-1:0] col;

  logic signed [BW-1:0] delta_q [rows];
  logic signed [DW-1:0] act_q   [columns];
  logic signed [DW-1:0] shadow  [columns];
  logic signed [DW-1:0] mac_u;

  logic [max_columns*DW-1:0] w_flat;
  logic [max_rows*BW-1:0]    b_flat;

  function automatic logic signed [BW-1:0] bias_of(
    input logic signed [BW-1:0] d
  );
    logic signed [BX-1:0] t;
    t = BX'(d);
`ifdef UPDATE_ROUND_EN
    t = t + BX'(rnd_off(LR_SHIFT));
`endif
    t = -(t >>> LR_SHIFT);
    if (t > BMAX) begin
      return BMAX[BW-1:0];
    end else if (t < BMIN) begin
      return BMIN[BW-1:0];
    end
    return t[BW-1:0];
  endfunction

  update_mac #(
    .datawidth (DW),
    .LR_SHIFT  (LR_SHIFT)
  ) u_mac (
    .delta (delta_q[row]),
    .x     (act_q[col]),
    .u     (mac_u)
  );

  always_comb begin
    w_flat = '0;
    for (int j = 0; j < columns; j++) begin
      w_flat[(columns-j-1)*DW +: DW] = shadow[j];
    end
  end

  always_comb begin
    b_flat = '0;
    for (int m = 0; m < rows; m++) begin
      b_flat[(rows-m-1)*BW +: BW] = bias_of(delta_q[m]);
    end
  end

  always_ff @(posedge clk or posedge rst_overall) begin
    if (rst_overall) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          nxt = COMPUTE;
        end
      end
      COMPUTE: begin
        if (col == LAST_COL) begin
          nxt = PULSE;
        end
      end
      PULSE: begin
        nxt = (row == LAST_ROW) ? FINISH : COMPUTE;
      end
      FINISH: begin
        nxt = IDLE;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_overall) begin
    if (rst_overall) begin
      row <= '0;
      col <= '0;
      for (int i = 0; i < rows; i++) begin
        delta_q[i] <= '0;
      end
      for (int j = 0; j < columns; j++) begin
        act_q[j]  <= '0;
        shadow[j] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            row <= '0;
            col <= '0;
            for (int i = 0; i < rows; i++) begin
              delta_q[i] <= deltas[(rows-i-1)*BW +: BW];
            end
            for (int j = 0; j < columns; j++) begin
              act_q[j] <= activations[(columns-j-1)*DW +: DW];
            end
          end
        end
        COMPUTE: begin
          shadow[col] <= mac_u;
          col         <= col + 1'b1;
        end
        PULSE: begin
          col <= '0;
          if (row != LAST_ROW) begin
            row <= row + 1'b1;
          end
        end
        default: begin
          col <= '0;
        end
      endcase
    end
  end

  // Bias rides only on the row-0 pulse so the layer adds it once per sweep
  always_ff @(posedge clk or posedge rst_overall) begin
    if (rst_overall) begin
      train_en      <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
      row_sel       <= '0;
      weight_update <= '0;
      bias_updates  <= '0;
    end else begin
      train_en     <= (state == PULSE);
      done         <= (state == FINISH);
      bias_updates <= (state == PULSE && row == '0) ? b_flat : '0;
      if (state == PULSE) begin
        row_sel       <= row;
        weight_update <= w_flat;
      end
      if (state == IDLE && start) begin
        busy <= 1'b1;
      end else if (state == FINISH) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_layer_update_gen.sv
// Directed plus randomized sweeps of layer_update_gen against a reference model.
// Tracks a layer-side bias accumulator to confirm single bias application.
module tb_layer_update_gen;

  localparam int R    = 2;
  localparam int C    = 3;
  localparam int DW   = 11;
  localparam int BW   = 2 * DW;
  localparam int SH   = 4;
  localparam int P    = C + 1;
  localparam int NEND = R * P + 1;

  logic                      clk = 1'b0;
  logic                      rst_overall;
  logic                      start;
  logic [R*BW-1:0]           deltas;
  logic [C*DW-1:0]           activations;
  logic [$clog2(R)-1:0]      row_sel;
  logic [C*DW-1:0]           weight_update;
  logic [R*BW-1:0]           bias_updates;
  logic                      train_en;
  logic                      busy;
  logic                      done;

  int compared   = 0;
  int mismatched = 0;

  longint dl [R];
  longint xa [C];
  longint acc [R] = '{default: 0};
  logic   te_prev = 1'b0;
  longint last_rs = 0;

  layer_update_gen #(
    .rows        (R),
    .columns     (C),
    .max_rows    (R),
    .max_columns (C),
    .datawidth   (DW),
    .LR_SHIFT    (SH)
  ) dut (
    .clk           (clk),
    .rst_overall   (rst_overall),
    .start         (start),
    .deltas        (deltas),
    .activations   (activations),
    .row_sel       (row_sel),
    .weight_update (weight_update),
    .bias_updates  (bias_updates),
    .train_en      (train_en),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Layer-side view: bias added on every train_en rising edge
  always @(negedge clk) begin
    if (train_en && !te_prev) begin
      for (int m = 0; m < R; m++) begin
        acc[m] += longint'($signed(bias_updates[(R-m-1)*BW +: BW]));
      end
    end
    te_prev = train_en;
  end

  function automatic longint floor_div(input longint a);
    longint d;
    longint q;
    d = longint'(2) ** SH;
    q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint clamp(input longint v, input int w);
    longint hi;
    hi = (longint'(2) ** (w - 1)) - 1;
    if (v > hi) return hi;
    if (v < -hi - 1) return -hi - 1;
    return v;
  endfunction

  function automatic longint scaled(input longint v);
`ifdef UPDATE_ROUND_EN
    if (SH > 0) v = v + (longint'(2) ** (SH - 1));
`endif
    return floor_div(v);
  endfunction

  function automatic longint w_ref(input longint d, input longint x);
    return clamp(-scaled(d * x), DW);
  endfunction

  function automatic longint b_ref(input longint d);
    return clamp(-scaled(d), BW);
  endfunction

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pack();
    for (int i = 0; i < R; i++) deltas[(R-i-1)*BW +: BW] = BW'(dl[i]);
    for (int j = 0; j < C; j++) activations[(C-j-1)*DW +: DW] = DW'(xa[j]);
  endtask

  task automatic rand_data(input bit wide);
    for (int i = 0; i < R; i++) begin
      if (wide) dl[i] = longint'($urandom_range(0, 4194303)) - 2097152;
      else      dl[i] = longint'($urandom_range(0, 800)) - 400;
    end
    for (int j = 0; j < C; j++) xa[j] = longint'($urandom_range(0, 2047)) - 1024;
  endtask

  // Runs one sweep; mask bit n drives start again so it is sampled at edge n
  task automatic sweep(input logic [31:0] mask);
    longint ew [R][C];
    longint eb [R];
    bit     exp_te;
    int     k;
    pack();
    for (int i = 0; i < R; i++) begin
      eb[i] = b_ref(dl[i]);
      for (int j = 0; j < C; j++) ew[i][j] = w_ref(dl[i], xa[j]);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_rise", busy, 1);
    chk("te_e0", train_en, 0);
    for (int n = 1; n <= NEND; n++) begin
      start = mask[n];
      tick();
      start = 1'b0;
      exp_te = (n % P == 0) && (n <= R * P);
      chk($sformatf("train_en n%0d", n), train_en, exp_te);
      chk($sformatf("done n%0d", n), done, n == NEND);
      chk($sformatf("busy n%0d", n), busy, n < NEND);
      if (exp_te) begin
        k = n / P - 1;
        last_rs = k;
        for (int j = 0; j < C; j++)
          chk($sformatf("w r%0d c%0d", k, j),
              $signed(weight_update[(C-j-1)*DW +: DW]), ew[k][j]);
        for (int m = 0; m < R; m++)
          chk($sformatf("b r%0d m%0d", k, m),
              $signed(bias_updates[(R-m-1)*BW +: BW]),
              (k == 0) ? eb[m] : 0);
      end else begin
        chk($sformatf("b_idle n%0d", n), bias_updates, 0);
      end
      chk($sformatf("row_sel n%0d", n), row_sel, last_rs);
    end
  endtask

  initial begin
    longint a0;
    longint a1;
    rst_overall = 1'b1;
    start       = 1'b0;
    deltas      = '0;
    activations = '0;
    tick();
    tick();
    chk("rst_te", train_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rs", row_sel, 0);
    chk("rst_w", weight_update, 0);
    chk("rst_b", bias_updates, 0);
    rst_overall = 1'b0;
    tick();

    // basic pattern, restarts at E2 and E5 plus one on the done edge
    dl = '{160, 0};
    xa = '{16, -32, 0};
    sweep(32'h0000_0224);
    tick();
    chk("idle_after_done_busy", busy, 0);
    chk("idle_after_done_te", train_en, 0);

    // saturation corners, back to back
    dl = '{2097151, -5};
    xa = '{1023, -1024, 1};
    sweep(0);
    dl = '{-2097152, 2097151};
    xa = '{1023, -1024, -1};
    sweep(0);

    // rounding corners
    dl = '{1, -1};
    xa = '{8, 8, -8};
    sweep(0);

    // reset while the first pulse is high
    rand_data(1'b0);
    pack();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("rst_pre_te", train_en, 1);
    #2 rst_overall = 1'b1;
    #1;
    chk("arst_te", train_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_rs", row_sel, 0);
    chk("arst_w", weight_update, 0);
    chk("arst_b", bias_updates, 0);
    tick();
    tick();
    rst_overall = 1'b0;
    last_rs = 0;
    for (int n = 7; n <= 10; n++) begin
      tick();
      chk($sformatf("post_rst_te n%0d", n), train_en, 0);
      chk($sformatf("post_rst_busy n%0d", n), busy, 0);
    end
    rand_data(1'b0);
    sweep(0);

    // bias applied once per sweep at the layer
    dl[0] = 160;
    dl[1] = longint'($urandom_range(0, 400)) - 200;
    for (int j = 0; j < C; j++) xa[j] = longint'($urandom_range(0, 2047)) - 1024;
    a0 = acc[0];
    a1 = acc[1];
    sweep(0);
    sweep(0);
    chk("bias_once_r0", acc[0] - a0, -20);
    chk("bias_once_r1", acc[1] - a1, 2 * b_ref(dl[1]));

    for (int t = 0; t < 8; t++) begin
      rand_data(t[0]);
      sweep($urandom & 32'h0000_03FE);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
